// File: rtl/bus_stream_pkg.sv
// rtl/bus_stream_pkg.sv - shared types and round-robin helper for the bus stream arbiter
package bus_stream_pkg;

  localparam int MAX_SRC = 8;

  // Wide enough for the largest supported source count; tops narrow it.
  typedef logic [2:0] src_idx_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Search starts one past the last grant and wraps at n-1; holds last if nothing requests.
  function automatic src_idx_t rr_pick(input logic [MAX_SRC-1:0] req, input src_idx_t last,
                                       input int n);
    src_idx_t pick;
    logic     found;
    int       idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !found && req[idx[2:0]]) begin
        pick  = src_idx_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_stream_fifo.sv
// rtl/bus_stream_fifo.sv - per-source synchronous FIFO with extra pointer bit for full/empty
module bus_stream_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              rd_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en    = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bus_stream_arbiter.sv
// rtl/bus_stream_arbiter.sv - merges NUM_SRC free-running sources into one valid/ready stream
module bus_stream_arbiter
  import bus_stream_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int DATA_W     = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int SRC_W      = clog2_min1(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic [NUM_SRC-1:0]        ovf_sticky,
  input  logic [NUM_SRC-1:0]        ovf_clr,
  output logic [NUM_SRC-1:0]        fifo_empty
);

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] drop;
  logic [NUM_SRC-1:0] req;
  logic [DATA_W-1:0]  head [NUM_SRC];
  src_idx_t           last_grant;
  src_idx_t           pick;
  logic [SRC_W-1:0]   grant;
  logic               load;

  assign req   = ~fifo_empty;
  assign pick  = rr_pick(MAX_SRC'(req), last_grant, NUM_SRC);
  assign grant = SRC_W'(pick);
  assign load  = (!out_valid || out_ready) && (|req);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign pop[i]  = load && (grant == SRC_W'(i));
    assign drop[i] = src_valid[i] && full[i] && !pop[i];

    bus_stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (src_valid[i]),
      .push_data (src_data[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .pop_data  (head[i]),
      .full      (full[i]),
      .empty     (fifo_empty[i])
    );
  end

  // Reset leaves last_grant at the top index so source 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= src_idx_t'(NUM_SRC - 1);
      ovf_sticky <= '0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= head[grant];
        out_src    <= grant;
        last_grant <= pick;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      ovf_sticky <= (ovf_sticky & ~ovf_clr) | drop;
    end
  end

endmodule

// File: tb/tb_bus_stream_arbiter.sv
// tb/tb_bus_stream_arbiter.sv - directed and randomized bench with a queue-based reference model
module tb_bus_stream_arbiter;

  localparam int NS    = 2;
  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic           clk;
  logic           rst_n;
  logic [NS-1:0]  src_valid;
  logic [NS*DW-1:0] src_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [0:0]     out_src;
  logic [NS-1:0]  ovf_sticky;
  logic [NS-1:0]  ovf_clr;
  logic [NS-1:0]  fifo_empty;

  int n_cmp = 0;
  int n_bad = 0;

  bus_stream_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .fifo_empty (fifo_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: one queue per source plus the single output slot.
  logic [DW-1:0] mq [NS][$];
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_last;
  logic [NS-1:0] m_ovf;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mq[i].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_last  = NS - 1;
    m_ovf   = '0;
  endtask

  task automatic model_step();
    bit            any;
    bit            found;
    int            g;
    logic [NS-1:0] drop;
    any = 0;
    g   = 0;
    for (int i = 0; i < NS; i++) if (mq[i].size() > 0) any = 1;
    if ((!m_valid || out_ready) && any) begin
      found = 0;
      for (int k = 1; k <= NS; k++) begin
        int c;
        c = (m_last + k) % NS;
        if (!found && mq[c].size() > 0) begin
          g = c;
          found = 1;
        end
      end
      m_data  = mq[g].pop_front();
      m_src   = g;
      m_last  = g;
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    drop = '0;
    for (int i = 0; i < NS; i++) begin
      if (src_valid[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(src_data[i*DW +: DW]);
        else drop[i] = 1'b1;
      end
    end
    m_ovf = (m_ovf & ~ovf_clr) | drop;
  endtask

  task automatic cycle(input logic [NS-1:0] v, input logic [NS*DW-1:0] d, input logic rdy,
                       input logic [NS-1:0] clr);
    src_valid = v;
    src_data  = d;
    out_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    src_valid = '0;
    src_data  = '0;
    out_ready = 1'b0;
    ovf_clr   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    src_valid = '0;
    src_data  = '0;
    out_ready = 1'b0;
    ovf_clr   = '0;
    model_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_cmp++; if (out_src !== 1'b0) begin n_bad++; $display("FAIL reset_src: got %b want 0", out_src); end
    n_cmp++; if (ovf_sticky !== 2'b00) begin n_bad++; $display("FAIL reset_ovf: got %b want 00", ovf_sticky); end
    n_cmp++; if (fifo_empty !== 2'b11) begin n_bad++; $display("FAIL reset_empty: got %b want 11", fifo_empty); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    do_reset();
    cycle(2'b01, 8'h0A, 1'b1, 2'b00);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", out_valid); end
    n_cmp++; if (fifo_empty !== 2'b10) begin n_bad++; $display("FAIL single_fifo: got %b want 10", fifo_empty); end
    cycle(2'b00, 8'h00, 1'b1, 2'b00);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 4'hA) begin n_bad++; $display("FAIL single_data: got %h want a", out_data); end
    n_cmp++; if (out_src !== 1'b0) begin n_bad++; $display("FAIL single_src: got %b want 0", out_src); end
    cycle(2'b00, 8'h00, 1'b1, 2'b00);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cycle(2'b11, 8'h21, 1'b1, 2'b00);
    cycle(2'b00, 8'h00, 1'b1, 2'b00);
    n_cmp++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 4'h1})
      begin n_bad++; $display("FAIL simul_first: got v%b s%b d%h want v1 s0 d1", out_valid, out_src, out_data); end
    cycle(2'b00, 8'h00, 1'b1, 2'b00);
    n_cmp++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 4'h2})
      begin n_bad++; $display("FAIL simul_second: got v%b s%b d%h want v1 s1 d2", out_valid, out_src, out_data); end
  endtask

  task automatic test_fairness();
    logic [DW-1:0] exp_q [NS][$];
    logic [NS*DW-1:0] d;
    logic [DW-1:0] want;
    logic exp_src;
    int beats;
    do_reset();
    exp_src = 1'b0;
    beats   = 0;
    for (int c = 0; c < 20; c++) begin
      d = (NS*DW)'($urandom);
      if (c < 7) begin
        for (int i = 0; i < NS; i++) exp_q[i].push_back(d[i*DW +: DW]);
        cycle(2'b11, d, 1'b1, 2'b00);
      end else begin
        cycle(2'b00, d, 1'b1, 2'b00);
      end
      if (out_valid === 1'b1) begin
        beats++;
        n_cmp++; if (out_src !== exp_src) begin n_bad++; $display("FAIL fair_src: beat %0d got %b want %b", beats, out_src, exp_src); end
        want = (exp_q[exp_src].size() > 0) ? exp_q[exp_src].pop_front() : 'x;
        n_cmp++; if (out_data !== want) begin n_bad++; $display("FAIL fair_data: beat %0d got %h want %h", beats, out_data, want); end
        exp_src = ~exp_src;
      end
    end
    n_cmp++; if (beats !== 14) begin n_bad++; $display("FAIL fair_count: got %0d want 14", beats); end
    n_cmp++; if (ovf_sticky !== 2'b00) begin n_bad++; $display("FAIL fair_ovf: got %b want 00", ovf_sticky); end
  endtask

  task automatic fill_src0_stalled();
    do_reset();
    for (int k = 0; k < 6; k++) cycle(2'b01, {4'h0, 4'(k)}, 1'b0, 2'b00);
  endtask

  task automatic test_backpressure();
    fill_src0_stalled();
    n_cmp++; if (ovf_sticky !== 2'b01) begin n_bad++; $display("FAIL bp_ovf: got %b want 01", ovf_sticky); end
    n_cmp++; if ({out_valid, out_data} !== {1'b1, 4'h0})
      begin n_bad++; $display("FAIL bp_hold: got v%b d%h want v1 d0", out_valid, out_data); end
    for (int k = 1; k <= 4; k++) begin
      cycle(2'b00, 8'h00, 1'b1, 2'b00);
      n_cmp++; if ({out_valid, out_data} !== {1'b1, 4'(k)})
        begin n_bad++; $display("FAIL bp_order: got v%b d%h want v1 d%0h", out_valid, out_data, k); end
    end
    cycle(2'b00, 8'h00, 1'b1, 2'b00);
    n_cmp++; if ({out_valid, fifo_empty} !== {1'b0, 2'b11})
      begin n_bad++; $display("FAIL bp_drain: got v%b e%b want v0 e11", out_valid, fifo_empty); end
  endtask

  task automatic test_ovf_clr();
    fill_src0_stalled();
    cycle(2'b01, 8'h06, 1'b0, 2'b01);
    n_cmp++; if (ovf_sticky[0] !== 1'b1) begin n_bad++; $display("FAIL ovf_clr_race: got %b want 1", ovf_sticky[0]); end
    cycle(2'b00, 8'h00, 1'b0, 2'b01);
    n_cmp++; if (ovf_sticky !== 2'b00) begin n_bad++; $display("FAIL ovf_clr_done: got %b want 00", ovf_sticky); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 1; k <= 3; k++) cycle(2'b01, {4'h0, 4'(k)}, 1'b0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if ({out_valid, fifo_empty} !== {1'b0, 2'b11})
      begin n_bad++; $display("FAIL midrst_flush: got v%b e%b want v0 e11", out_valid, fifo_empty); end
    #2 rst_n = 1'b1;
    cycle(2'b11, 8'h57, 1'b0, 2'b00);
    cycle(2'b00, 8'h00, 1'b0, 2'b00);
    n_cmp++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 4'h7})
      begin n_bad++; $display("FAIL midrst_first: got v%b s%b d%h want v1 s0 d7", out_valid, out_src, out_data); end
    cycle(2'b00, 8'h00, 1'b1, 2'b00);
    n_cmp++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 4'h5})
      begin n_bad++; $display("FAIL midrst_second: got v%b s%b d%h want v1 s1 d5", out_valid, out_src, out_data); end
  endtask

  task automatic test_random();
    logic rdy;
    logic [NS-1:0] clr;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rdy = ((c / 100) % 2 == 1) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      clr = ($urandom_range(5) == 0) ? NS'($urandom) : '0;
      cycle(NS'($urandom), (NS*DW)'($urandom), rdy, clr);
      n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid: cyc %0d got %b want %b", c, out_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (out_data !== m_data) begin n_bad++; $display("FAIL rand_data: cyc %0d got %h want %h", c, out_data, m_data); end
        n_cmp++; if (out_src !== 1'(m_src)) begin n_bad++; $display("FAIL rand_src: cyc %0d got %b want %0d", c, out_src, m_src); end
      end
      n_cmp++; if (ovf_sticky !== m_ovf) begin n_bad++; $display("FAIL rand_ovf: cyc %0d got %b want %b", c, ovf_sticky, m_ovf); end
      for (int i = 0; i < NS; i++) begin
        n_cmp++; if (fifo_empty[i] !== (mq[i].size() == 0))
          begin n_bad++; $display("FAIL rand_empty: cyc %0d src %0d got %b want %b", c, i, fifo_empty[i], mq[i].size() == 0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_ovf_clr();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
